// File: rtl/systolic_pkg.sv
// Shared constants, types and FSM encoding for the 2x2 systolic operand feeder.
package systolic_pkg;
    localparam int DATA_W       = 8;
    localparam int N            = 2;
    localparam int FEED_CYCLES  = 2 * N - 1;
    localparam int DRAIN_CYCLES = N;

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [N*N-1:0]   mat_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } feed_state_t;
endpackage

// File: rtl/feeder_matrix_buf.sv
// 2x2 operand register bank, element index row*2+col, all elements visible at once.
module feeder_matrix_buf
    import systolic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [1:0] addr,
    input  elem_t      wdata,
    output mat_t       mat
);
    mat_t mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign mat = mem;
endmodule

// File: rtl/systolic_feeder_2by2.sv
// Operand feeder for a 2x2 output-stationary array: clear, skewed feed, drain, done.
//
//   state | meaning
//   IDLE  | matrices writable, waiting for start
//   CLEAR | one-cycle pe_clear pulse to zero the accumulators
//   FEED  | step 0..2, skewed A rows / B columns, valid high
//   DRAIN | step 0..1, zero operands while PE(1,1) finishes
//   DONE  | one-cycle done pulse
module systolic_feeder_2by2
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [1:0]        load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pe_clear,
    output logic              valid,
    output logic [DATA_W-1:0] a_row0,
    output logic [DATA_W-1:0] a_row1,
    output logic [DATA_W-1:0] b_col0,
    output logic [DATA_W-1:0] b_col1
);
    localparam logic [1:0] FEED_LAST  = 2'(FEED_CYCLES - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    feed_state_t state, state_nxt;
    logic [1:0]  step, step_nxt;
    mat_t        mat_a, mat_b;
    elem_t       a0_nxt, a1_nxt, b0_nxt, b1_nxt;
    logic        in_idle;

    assign in_idle = (state == IDLE);

    feeder_matrix_buf u_buf_a (
        .clk   (clk),
        .reset (reset),
        .we    (load_en && in_idle && !load_sel),
        .addr  (load_addr),
        .wdata (load_data),
        .mat   (mat_a)
    );

    feeder_matrix_buf u_buf_b (
        .clk   (clk),
        .reset (reset),
        .we    (load_en && in_idle && load_sel),
        .addr  (load_addr),
        .wdata (load_data),
        .mat   (mat_b)
    );

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            IDLE:  if (start) state_nxt = CLEAR;
            CLEAR: begin
                state_nxt = FEED;
                step_nxt  = '0;
            end
            FEED: begin
                if (step == FEED_LAST) begin
                    state_nxt = DRAIN;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + 2'd1;
                end
            end
            DRAIN: begin
                if (step == DRAIN_LAST) begin
                    state_nxt = DONE;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + 2'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so the skew uses the step being entered.
    always_comb begin
        a0_nxt = '0;
        a1_nxt = '0;
        b0_nxt = '0;
        b1_nxt = '0;
        if (state_nxt == FEED) begin
            case (step_nxt)
                2'd0: begin
                    a0_nxt = mat_a[0];
                    b0_nxt = mat_b[0];
                end
                2'd1: begin
                    a0_nxt = mat_a[1];
                    a1_nxt = mat_a[2];
                    b0_nxt = mat_b[2];
                    b1_nxt = mat_b[1];
                end
                2'd2: begin
                    a1_nxt = mat_a[3];
                    b1_nxt = mat_b[3];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pe_clear <= 1'b0;
            valid    <= 1'b0;
            a_row0   <= '0;
            a_row1   <= '0;
            b_col0   <= '0;
            b_col1   <= '0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
            pe_clear <= (state_nxt == CLEAR);
            valid    <= (state_nxt == FEED);
            a_row0   <= a0_nxt;
            a_row1   <= a1_nxt;
            b_col0   <= b0_nxt;
            b_col1   <= b1_nxt;
        end
    end
endmodule

// File: tb/tb_systolic_feeder_2by2.sv
// Directed bench for the 2x2 feeder with a behavioural PE array on its outputs.
module tb_systolic_feeder_2by2;
    typedef logic [7:0] seq_t [3][4];
    typedef logic [7:0] cmat_t [4];

    logic       clk = 1'b0;
    logic       reset, load_en, load_sel, start;
    logic [1:0] load_addr;
    logic [7:0] load_data;
    logic       busy, done, pe_clear, valid;
    logic [7:0] a_row0, a_row1, b_col0, b_col1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] acc00, acc01, acc10, acc11;
    logic [7:0] ar00, ar10, bd00, bd01;

    always #5 clk = ~clk;

    systolic_feeder_2by2 dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pe_clear  (pe_clear),
        .valid     (valid),
        .a_row0    (a_row0),
        .a_row1    (a_row1),
        .b_col0    (b_col0),
        .b_col1    (b_col1)
    );

    // Output-stationary PE grid: operands move right/down one cycle per PE.
    always @(posedge clk) begin
        if (reset || pe_clear) begin
            acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
            ar00  <= '0; ar10  <= '0; bd00  <= '0; bd01  <= '0;
        end else begin
            acc00 <= acc00 + a_row0 * b_col0;
            acc01 <= acc01 + ar00 * b_col1;
            acc10 <= acc10 + a_row1 * bd00;
            acc11 <= acc11 + ar10 * bd01;
            ar00  <= a_row0;
            ar10  <= a_row1;
            bd00  <= b_col0;
            bd01  <= b_col1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input logic sel, input logic [1:0] addr, input logic [7:0] data);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = addr;
        load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic load_mats(input cmat_t ma, input cmat_t mb);
        for (int i = 0; i < 4; i++) write_elem(1'b0, 2'(i), ma[i]);
        for (int i = 0; i < 4; i++) write_elem(1'b1, 2'(i), mb[i]);
    endtask

    task automatic check_ops(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        check_val({tag, ".a_row0"}, 32'(a_row0), 32'(e0));
        check_val({tag, ".a_row1"}, 32'(a_row1), 32'(e1));
        check_val({tag, ".b_col0"}, 32'(b_col0), 32'(e2));
        check_val({tag, ".b_col1"}, 32'(b_col1), 32'(e3));
    endtask

    // Pulses start in the current cycle; returns while in the DONE cycle.
    // With disturb set, a load of 99 into A00 and a second start are driven during FEED.
    task automatic do_run(input string tag, input seq_t e, input bit disturb);
        start = 1'b1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        check_val({tag, ".clear"}, 32'(pe_clear), 32'd1);
        check_val({tag, ".clear_busy"}, 32'(busy), 32'd1);
        check_val({tag, ".clear_valid"}, 32'(valid), 32'd0);
        for (int t = 0; t < 3; t++) begin
            tick();
            if (disturb && t == 0) begin
                load_en = 1'b1; load_sel = 1'b0; load_addr = 2'd0; load_data = 8'd99;
                start   = 1'b1;
            end else begin
                load_en = 1'b0;
                start   = 1'b0;
            end
            check_val($sformatf("%s.t%0d.valid", tag, t), 32'(valid), 32'd1);
            check_val($sformatf("%s.t%0d.clear", tag, t), 32'(pe_clear), 32'd0);
            check_ops($sformatf("%s.t%0d", tag, t), e[t][0], e[t][1], e[t][2], e[t][3]);
        end
        load_en = 1'b0;
        start   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tick();
            check_val($sformatf("%s.drain%0d.valid", tag, d), 32'(valid), 32'd0);
            check_val($sformatf("%s.drain%0d.done", tag, d), 32'(done), 32'd0);
            check_val($sformatf("%s.drain%0d.busy", tag, d), 32'(busy), 32'd1);
            check_ops($sformatf("%s.drain%0d", tag, d), 8'd0, 8'd0, 8'd0, 8'd0);
        end
        tick();
        check_val({tag, ".done"}, 32'(done), 32'd1);
        check_val({tag, ".done_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic check_c(input string tag, input cmat_t e);
        check_val({tag, ".c00"}, 32'(acc00), 32'(e[0]));
        check_val({tag, ".c01"}, 32'(acc01), 32'(e[1]));
        check_val({tag, ".c10"}, 32'(acc10), 32'(e[2]));
        check_val({tag, ".c11"}, 32'(acc11), 32'(e[3]));
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".busy"}, 32'(busy), 32'd0);
        check_val({tag, ".done"}, 32'(done), 32'd0);
        check_val({tag, ".clear"}, 32'(pe_clear), 32'd0);
        check_val({tag, ".valid"}, 32'(valid), 32'd0);
        check_ops(tag, 8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    seq_t  seq_base, seq_zero, seq_b20, seq_16;
    cmat_t mat_a, mat_b, mat_16, c_base, c_zero, c_b20;

    initial begin
        seq_base = '{'{8'd1, 8'd0, 8'd5, 8'd0}, '{8'd2, 8'd3, 8'd7, 8'd6}, '{8'd0, 8'd4, 8'd0, 8'd8}};
        seq_zero = '{'{8'd0, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0, 8'd0}};
        seq_b20  = '{'{8'd1, 8'd0, 8'd5, 8'd0}, '{8'd2, 8'd3, 8'd7, 8'd6}, '{8'd0, 8'd4, 8'd0, 8'd20}};
        seq_16   = '{'{8'd16, 8'd0, 8'd16, 8'd0}, '{8'd16, 8'd16, 8'd16, 8'd16}, '{8'd0, 8'd16, 8'd0, 8'd16}};
        mat_a  = '{8'd1, 8'd2, 8'd3, 8'd4};
        mat_b  = '{8'd5, 8'd6, 8'd7, 8'd8};
        mat_16 = '{8'd16, 8'd16, 8'd16, 8'd16};
        c_base = '{8'd19, 8'd22, 8'd43, 8'd50};
        c_zero = '{8'd0, 8'd0, 8'd0, 8'd0};
        c_b20  = '{8'd19, 8'd46, 8'd43, 8'd98};

        reset = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        // Basic product
        load_mats(mat_a, mat_b);
        do_run("run1", seq_base, 1'b0);
        check_c("run1", c_base);
        tick();
        check_idle("run1_idle");

        // Reset during FEED step 1 aborts and clears matrices
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_val("abort.pre_valid", 32'(valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val($sformatf("abort.nodone%0d", i), 32'(done | busy), 32'd0);
        end
        do_run("zero", seq_zero, 1'b0);
        check_c("zero", c_zero);
        tick();

        // Loads and start while busy are ignored
        load_mats(mat_a, mat_b);
        do_run("disturb", seq_base, 1'b1);
        check_c("disturb", c_base);
        tick();
        check_idle("disturb_idle");
        do_run("after_disturb", seq_base, 1'b0);
        check_c("after_disturb", c_base);
        tick();

        // Write and start in the same IDLE cycle
        load_en = 1'b1; load_sel = 1'b1; load_addr = 2'd3; load_data = 8'd20;
        do_run("same_cycle", seq_b20, 1'b0);
        check_c("same_cycle", c_b20);
        tick();

        // Products wrap in the PE; operands pass unchanged
        load_mats(mat_16, mat_16);
        do_run("wrap", seq_16, 1'b0);
        check_c("wrap", c_zero);
        tick();

        // Back-to-back runs, second start right after DONE
        load_mats(mat_a, mat_b);
        do_run("b2b1", seq_base, 1'b0);
        check_c("b2b1", c_base);
        tick();
        check_val("b2b.idle_busy", 32'(busy), 32'd0);
        do_run("b2b2", seq_base, 1'b0);
        check_c("b2b2", c_base);
        tick();
        check_idle("end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/systolic_feeder_2by2.md
Name: systolic_feeder_2by2

Overview:
Upstream operand feeder for the 2x2 output-stationary systolic array built from pe_2by2 cells.
- Buffers two 2x2 matrices, A and B, written one element per cycle.
- On start, clears the PE accumulators, then streams A rows into the left edge and B columns into the top edge with diagonal skew and zero padding.
- Holds for drain cycles so PE(1,1) finishes, then pulses done.

Parameters:
DATA_W, 8, operand width (matches the PE data width).
N, 2, array dimension. Fixed at 2; the schedule below is written for N=2.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
load_en  input  1  write one matrix element this cycle.
load_sel  input  1  0 = matrix A, 1 = matrix B.
load_addr  input  2  element index = row*2 + col.
load_data  input  DATA_W  element value.
start  input  1  begin a feed sequence; accepted only in IDLE.
busy  output  1  high in CLEAR, FEED, DRAIN and DONE.
done  output  1  one-cycle pulse in DONE.
pe_clear  output  1  one-cycle pulse; ORed with reset at each PE's reset input.
valid  output  1  high during FEED cycles.
a_row0  output  DATA_W  left-edge operand, array row 0.
a_row1  output  DATA_W  left-edge operand, array row 1.
b_col0  output  DATA_W  top-edge operand, array column 0.
b_col1  output  DATA_W  top-edge operand, array column 1.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state=IDLE; step=0; all outputs 0; all matrix storage 0.
- Reset mid-operation: abort at the next edge, return to IDLE, no done pulse. Stored matrices are cleared.
- Outputs: all registered.
- Loads:
  - Accepted only in IDLE; load_en in any other state is ignored.
  - A write takes effect at the edge where it is sampled.
  - load_en and start in the same IDLE cycle: the write is committed and the feed uses the new value.
- start outside IDLE: ignored, never queued.
- FSM, 3-bit state, 2-bit step counter:
  - IDLE -> CLEAR on start.
  - CLEAR: lasts 1 cycle, pe_clear=1, -> FEED with step=0.
  - FEED: lasts 2N-1 = 3 cycles, valid=1, step 0..2, -> DRAIN.
  - DRAIN: lasts N = 2 cycles, all operands 0, -> DONE.
  - DONE: lasts 1 cycle, done=1, -> IDLE.
- Timing: with start sampled at edge k:
  - pe_clear is visible in cycle k+1.
  - FEED occupies cycles k+2..k+4.
  - DRAIN occupies k+5..k+6.
  - done is visible in cycle k+7.
  - Total 7 cycles from start to done.
- Skew rule at FEED step t:
  - a_row_i = A[i][t-i] if 0 <= t-i < 2, else 0.
  - b_col_j = B[t-j][j] if 0 <= t-j < 2, else 0.
- Outside FEED, all four operand outputs are 0. The PE accumulators therefore receive only zero products.
- No arithmetic in this block. Operands pass unmodified; product truncation to DATA_W happens in the PE.
- Back-to-back runs: a start sampled in the IDLE cycle immediately after DONE is accepted. Matrices are retained between runs.

Decomposition:
- Shared package systolic_pkg:
  - DATA_W and N constants.
  - FEED_CYCLES=3 and DRAIN_CYCLES=2.
  - Feeder state enum {IDLE, CLEAR, FEED, DRAIN, DONE}.
- One natural sub-module, feeder_matrix_buf:
  - 2x2 DATA_W register bank with a synchronous write port, cleared on reset.
  - Exposes all four elements combinationally.
  - Instantiated twice, once for A and once for B.
- FSM and skew muxing live in the top module.

Test Plan:
1. Load A=[[1,2],[3,4]], B=[[5,6],[7,8]], then start. Required operand sequence (a_row0, a_row1, b_col0, b_col1):
   - FEED t0: (1,0,5,0).
   - FEED t1: (2,3,7,6).
   - FEED t2: (0,4,0,8).
   - valid=1 for exactly these 3 cycles; done at k+7.
   - With 4 pe_2by2 instances attached, outputs read after done are C=[[19,22],[43,50]].
2. Reset timing: assert reset for 1 cycle during FEED step 1 -> next cycle all outputs 0, busy=0, no done pulse. Then start with no reloads -> all operands 0 throughout FEED.
3. load_en with value 99 to A[0][0] while busy, plus start pulsed during FEED -> both ignored. The sequence completes unchanged and the next run still feeds A00=1.
4. In one IDLE cycle, load_en writes B[1][1]=20 together with start -> FEED t2 shows b_col1=20.
5. Overflow case A=[[16,16],[16,16]], B=[[16,16],[16,16]] -> operands pass unmodified as 16. With PEs attached, every C = 0 (512 truncated to 8 bits).
6. Two back-to-back runs, second start in the cycle after done -> second CLEAR pulse at the expected cycle and identical results. No stale accumulation in C.
